// File: rtl/instr_fetch_if.sv
// Fetch-side bus: the instruction memory read port, the redirect input from
// branch resolution, and the IF/ID valid/ready output towards decode.
interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus4
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4
  );
endinterface

// File: rtl/instr_fetch.sv
// MIPS fetch stage: owns the PC, reads instruction memory combinationally and
// registers {instr, pc} into IF/ID; an illegal fetch latches a sticky fault.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_SIZE = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_fetch_if.master  bus,
  output logic           fault,
  output logic [31:0]    fault_pc,
  output logic [31:0]    fetch_count
);

  localparam logic [0:0]  ST_RUN    = 1'b0;
  localparam logic [0:0]  ST_HALT   = 1'b1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_SIZE * 4);

  logic [0:0]  state;
  logic [31:0] pc;
  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_pc_q;
  logic [31:0] out_pc_plus4_q;
  logic        redirect_bad;
  logic        pc_bad;

  assign bus.imem_addr    = pc;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_instr    = out_instr_q;
  assign bus.out_pc       = out_pc_q;
  assign bus.out_pc_plus4 = out_pc_plus4_q;

  assign redirect_bad = (bus.redirect_pc[1:0] != 2'b00) || (bus.redirect_pc >= MEM_BYTES);
  assign pc_bad       = (pc >= MEM_BYTES);

  // A handshake on the redirect edge still counts as consumed, so the counter
  // runs independently of the redirect/fetch priority below.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      pc             <= RESET_PC;
      out_valid_q    <= 1'b0;
      out_instr_q    <= 32'h0000_0000;
      out_pc_q       <= 32'h0000_0000;
      out_pc_plus4_q <= 32'h0000_0004;
      fault          <= 1'b0;
      fault_pc       <= 32'h0000_0000;
      fetch_count    <= 32'h0000_0000;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        fetch_count <= fetch_count + 32'd1;
      end

      if (state == ST_RUN) begin
        if (bus.redirect_valid) begin
          out_valid_q <= 1'b0;
          if (redirect_bad) begin
            fault    <= 1'b1;
            fault_pc <= bus.redirect_pc;
            state    <= ST_HALT;
          end else begin
            pc <= bus.redirect_pc;
          end
        end else if (!out_valid_q || bus.out_ready) begin
          if (pc_bad) begin
            fault       <= 1'b1;
            fault_pc    <= pc;
            state       <= ST_HALT;
            out_valid_q <= 1'b0;
          end else begin
            out_instr_q    <= bus.imem_instr;
            out_pc_q       <= pc;
            out_pc_plus4_q <= pc + 32'd4;
            out_valid_q    <= 1'b1;
            pc             <= pc + 32'd4;
          end
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a 256-word instance for streaming, stall and redirect
// cases, and a 4-word instance for sequential run-off and range faults.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
    logic        ef;
    logic [31:0] efpc;
    logic [31:0] ecnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        faultA, faultB;
  logic [31:0] faultPcA, faultPcB, fetchCountA, fetchCountB;
  int          nVectors = 0;
  int          nMiscompares = 0;
  exp_t        sb[$];
  vec_t        vecs[13];

  instr_fetch_if busA();
  instr_fetch_if busB();

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr, input int words);
    if (addr < 32'(words * 4)) return 32'h1000_0000 + (addr >> 2);
    return 32'hDEAD_BEEF;
  endfunction

  assign busA.imem_instr = memWord(busA.imem_addr, 256);
  assign busB.imem_instr = memWord(busB.imem_addr, 4);

  instr_fetch #(.RESET_PC(32'h0000_0000), .MEM_SIZE(256)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(busA),
    .fault(faultA), .fault_pc(faultPcA), .fetch_count(fetchCountA)
  );

  instr_fetch #(.RESET_PC(32'h0000_0000), .MEM_SIZE(4)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(busB),
    .fault(faultB), .fault_pc(faultPcB), .fetch_count(fetchCountB)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit toB, input logic rv, input logic [31:0] rpc, input logic rdy);
    if (toB) begin
      busB.redirect_valid = rv;
      busB.redirect_pc    = rpc;
      busB.out_ready      = rdy;
    end else begin
      busA.redirect_valid = rv;
      busA.redirect_pc    = rpc;
      busA.out_ready      = rdy;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic popCompare(input string name, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] plus4);
    exp_t e;
    nVectors++;
    if (sb.size() == 0) begin
      nMiscompares++;
      $display("[TB] FAIL %s.sb: got pc %h with empty scoreboard, expected none", name, pc);
    end else begin
      nVectors--;
      e = sb.pop_front();
      checkOutput({name, ".pc"}, pc, e.pc);
      checkOutput({name, ".instr"}, instr, e.instr);
      checkOutput({name, ".plus4"}, plus4, e.pc + 32'd4);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] expCount;

    // Stall at out_pc=8, redirect flush, simultaneous handshake+redirect, then misaligned fault.
    vecs[0]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h08, 32'h1000_0002, 32'h0C, 1'b0, 32'h0,  32'd2};
    vecs[1]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h08, 32'h1000_0002, 32'h0C, 1'b0, 32'h0,  32'd2};
    vecs[2]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h08, 32'h1000_0002, 32'h0C, 1'b0, 32'h0,  32'd2};
    vecs[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0C, 32'h1000_0003, 32'h10, 1'b0, 32'h0,  32'd3};
    vecs[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h10, 32'h1000_0004, 32'h14, 1'b0, 32'h0,  32'd4};
    vecs[5]  = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h10, 32'h1000_0004, 32'h40, 1'b0, 32'h0,  32'd4};
    vecs[6]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h40, 32'h1000_0010, 32'h44, 1'b0, 32'h0,  32'd4};
    vecs[7]  = '{1'b1, 32'h80,  1'b1, 1'b0, 32'h40, 32'h1000_0010, 32'h80, 1'b0, 32'h0,  32'd5};
    vecs[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h80, 32'h1000_0020, 32'h84, 1'b0, 32'h0,  32'd5};
    vecs[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h84, 32'h1000_0021, 32'h88, 1'b0, 32'h0,  32'd6};
    vecs[10] = '{1'b1, 32'h42,  1'b0, 1'b0, 32'h84, 32'h1000_0021, 32'h88, 1'b1, 32'h42, 32'd6};
    vecs[11] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h84, 32'h1000_0021, 32'h88, 1'b1, 32'h42, 32'd6};
    vecs[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h84, 32'h1000_0021, 32'h88, 1'b1, 32'h42, 32'd6};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick;
    tick;
    checkOutput("rstA.valid", 32'(busA.out_valid), 32'h0);
    checkOutput("rstA.instr", busA.out_instr, 32'h0);
    checkOutput("rstA.pc", busA.out_pc, 32'h0);
    checkOutput("rstA.plus4", busA.out_pc_plus4, 32'h4);
    checkOutput("rstA.addr", busA.imem_addr, 32'h0);
    checkOutput("rstA.fault", 32'(faultA), 32'h0);
    checkOutput("rstA.faultPc", faultPcA, 32'h0);
    checkOutput("rstA.count", fetchCountA, 32'h0);

    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) sb.push_back('{32'(k * 4), 32'h1000_0000 + 32'(k)});
    expCount = 32'd0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput($sformatf("streamA%0d.count", i), fetchCountA, expCount);
      checkOutput($sformatf("streamA%0d.valid", i), 32'(busA.out_valid), 32'h1);
      popCompare($sformatf("streamA%0d", i), busA.out_pc, busA.out_instr, busA.out_pc_plus4);
      if (i < 2) expCount++;
    end

    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b0, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      tick;
      checkOutput($sformatf("v%0d.valid", i), 32'(busA.out_valid), 32'(vecs[i].ev));
      checkOutput($sformatf("v%0d.pc", i), busA.out_pc, vecs[i].epc);
      checkOutput($sformatf("v%0d.instr", i), busA.out_instr, vecs[i].einstr);
      checkOutput($sformatf("v%0d.addr", i), busA.imem_addr, vecs[i].eaddr);
      checkOutput($sformatf("v%0d.fault", i), 32'(faultA), 32'(vecs[i].ef));
      checkOutput($sformatf("v%0d.faultPc", i), faultPcA, vecs[i].efpc);
      checkOutput($sformatf("v%0d.count", i), fetchCountA, vecs[i].ecnt);
    end

    // Reset while a redirect is asserted: reset wins and clears the fault.
    applyStimulus(1'b0, 1'b1, 32'h80, 1'b1);
    rst_n = 1'b0;
    tick;
    checkOutput("rst2A.valid", 32'(busA.out_valid), 32'h0);
    checkOutput("rst2A.pc", busA.out_pc, 32'h0);
    checkOutput("rst2A.plus4", busA.out_pc_plus4, 32'h4);
    checkOutput("rst2A.addr", busA.imem_addr, 32'h0);
    checkOutput("rst2A.fault", 32'(faultA), 32'h0);
    checkOutput("rst2A.faultPc", faultPcA, 32'h0);
    checkOutput("rst2A.count", fetchCountA, 32'h0);

    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) sb.push_back('{32'(k * 4), 32'h1000_0000 + 32'(k)});
    for (int i = 0; i < 4; i++) begin
      tick;
      checkOutput($sformatf("runB%0d.valid", i), 32'(busB.out_valid), 32'h1);
      popCompare($sformatf("runB%0d", i), busB.out_pc, busB.out_instr, busB.out_pc_plus4);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      checkOutput($sformatf("offB%0d.fault", i), 32'(faultB), 32'h1);
      checkOutput($sformatf("offB%0d.faultPc", i), faultPcB, 32'h10);
      checkOutput($sformatf("offB%0d.valid", i), 32'(busB.out_valid), 32'h0);
      checkOutput($sformatf("offB%0d.count", i), fetchCountB, 32'd4);
      checkOutput($sformatf("offB%0d.addr", i), busB.imem_addr, 32'h10);
    end

    // Range edge on the 4-word memory: 0xC is the last legal target, 0x10 faults.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h0C, 1'b0);
    tick;
    checkOutput("edgeB.legalFault", 32'(faultB), 32'h0);
    checkOutput("edgeB.legalAddr", busB.imem_addr, 32'h0C);
    applyStimulus(1'b1, 1'b1, 32'h10, 1'b0);
    tick;
    checkOutput("edgeB.fault", 32'(faultB), 32'h1);
    checkOutput("edgeB.faultPc", faultPcB, 32'h10);
    checkOutput("edgeB.addr", busB.imem_addr, 32'h0C);
    checkOutput("edgeB.valid", 32'(busB.out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
